queue_sched: RTL

- Sequencer between the deserializer (producer), the 8-entry byte queue and a downstream byte consumer.
- Converts the deserializer's level-valid into single-cycle queue enqueue pulses and returns an ack to the deserializer.
- Issues dequeue pulses on a drain policy (fill threshold or idle timeout) and presents dequeued bytes on a valid/ack interface.
- Guarantees that enqueue and dequeue are never asserted in the same cycle, because the queue's length update is not defined for simultaneous ops.

---
 rtl/queue_pkg.sv | 15 +
 rtl/sat_counter.sv | 29 ++
 rtl/queue_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/queue_pkg.sv
// Shared definitions for the queue sequencer and the 8-entry byte queue it drives.
package queue_pkg;

   localparam int QUEUE_DEPTH = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ENQ      = 3'd1,
      ENQ_WAIT = 3'd2,
      DEQ      = 3'd3,
      DEQ_WAIT = 3'd4,
      PRESENT  = 3'd5
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at LIMIT; clear has priority over enable.
module sat_counter #(
   parameter int WIDTH = 10,
   parameter int LIMIT = 1000
) (
   input  logic clock_10k,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic at_limit
);

   localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clock_10k or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIM)) begin
         count <= count + 1'b1;
      end
   end

   assign at_limit = (count == LIM);

endmodule

// File: rtl/queue_sched.sv
// Sequences enqueue/dequeue strobes for the byte queue and presents drained bytes
// to the consumer; enqueue and dequeue are never issued in the same cycle.
module queue_sched
   import queue_pkg::*;
#(
   parameter int DRAIN_THRESHOLD = 8,
   parameter int IDLE_TIMEOUT    = 1000,
   parameter int RESP_TIMEOUT    = 4
) (
   input  logic       clock_10k,
   input  logic       reset,
   input  logic       des_valid_in,
   output logic       des_ack_out,
   output logic       q_enq_out,
   output logic       q_deq_out,
   input  logic [7:0] q_data_in,
   input  logic [3:0] q_len_in,
   input  logic       q_status_in,
   input  logic       q_ack_in,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ack_in,
   output logic       drain_active,
   output logic       overflow_err,
   output logic       resp_err,
   output logic [2:0] fsm_state
);

   // Handshakes: des_valid_in is a level held by the producer until des_ack_out
   // pulses; out_valid is held with stable out_data until out_ack_in is seen in PRESENT.

   localparam logic [3:0] DEPTH  = 4'(QUEUE_DEPTH);
   localparam logic [3:0] THRESH = 4'(DRAIN_THRESHOLD);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
   localparam int RESP_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

   state_t     state, state_next;
   logic       byte_taken, byte_taken_next;
   logic       enq_next, deq_next, des_ack_next;
   logic       out_valid_next, drain_next, overflow_next, resp_next;
   logic [7:0] out_data_next;
   logic       pending, len_zero, idle_at_limit, resp_expired, idle_expired;

   assign pending      = des_valid_in && !byte_taken;
   assign len_zero     = (q_len_in == 4'd0);
   assign idle_expired = idle_at_limit && !len_zero;
   assign fsm_state    = state;

   sat_counter #(.WIDTH(IDLE_W), .LIMIT(IDLE_TIMEOUT)) u_idle_cnt (
      .clock_10k (clock_10k),
      .reset     (reset),
      .clear     (pending || len_zero),
      .enable    (1'b1),
      .at_limit  (idle_at_limit)
   );

   // Counts cycles spent in ENQ_WAIT; expires on the last allowed cycle.
   sat_counter #(.WIDTH(RESP_W), .LIMIT(RESP_TIMEOUT - 1)) u_resp_cnt (
      .clock_10k (clock_10k),
      .reset     (reset),
      .clear     (state != ENQ_WAIT),
      .enable    (1'b1),
      .at_limit  (resp_expired)
   );

   always_comb begin
      state_next      = state;
      des_ack_next    = 1'b0;
      byte_taken_next = byte_taken;
      out_valid_next  = out_valid;
      out_data_next   = out_data;
      drain_next      = drain_active;
      overflow_next   = overflow_err;
      resp_next       = resp_err;

      if (!des_valid_in) byte_taken_next = 1'b0;

      if ((q_len_in >= THRESH) || idle_expired) drain_next = 1'b1;
      else if ((state == IDLE) && len_zero)     drain_next = 1'b0;

      case (state)
         IDLE: begin
            if (drain_active && !len_zero) begin
               state_next = DEQ;
            end else if (pending && (q_len_in < DEPTH)) begin
               state_next = ENQ;
            end else if (pending) begin
               drain_next = 1'b1;
               state_next = DEQ;
            end
         end
         ENQ:      state_next = ENQ_WAIT;
         ENQ_WAIT: begin
            if (q_ack_in) begin
               des_ack_next    = 1'b1;
               byte_taken_next = 1'b1;
               state_next      = IDLE;
            end else if (q_status_in) begin
               overflow_next = 1'b1;
               state_next    = IDLE;
            end else if (resp_expired) begin
               resp_next  = 1'b1;
               state_next = IDLE;
            end
         end
         DEQ:      state_next = DEQ_WAIT;
         DEQ_WAIT: begin
            out_data_next  = q_data_in;
            out_valid_next = 1'b1;
            state_next     = PRESENT;
         end
         PRESENT: begin
            if (out_ack_in) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default:  state_next = IDLE;
      endcase

      enq_next = (state_next == ENQ);
      deq_next = (state_next == DEQ);
   end

   always_ff @(posedge clock_10k or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         byte_taken   <= 1'b0;
         q_enq_out    <= 1'b0;
         q_deq_out    <= 1'b0;
         des_ack_out  <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= 8'h00;
         drain_active <= 1'b0;
         overflow_err <= 1'b0;
         resp_err     <= 1'b0;
      end else begin
         state        <= state_next;
         byte_taken   <= byte_taken_next;
         q_enq_out    <= enq_next;
         q_deq_out    <= deq_next;
         des_ack_out  <= des_ack_next;
         out_valid    <= out_valid_next;
         out_data     <= out_data_next;
         drain_active <= drain_next;
         overflow_err <= overflow_next;
         resp_err     <= resp_next;
      end
   end

endmodule
